factor_mult_seq: RTL

- Sequential shift-and-add multiplier with a valid/ready handshake on each side.
- Accepts a candidate factor pair (x, y) and a 128-bit target, computes x*y one multiplier bit per cycle, and reports:
  - the full product,
  - whether the pair is nontrivial (both factors > 1),
  - whether the product equals the target.
- This is the constructive counterpart of the lab factor-search checks: formal proposes factors, this block multiplies them back and confirms. It sits in the single-property lab next to the BMC harness and is driven by a bench or an upstream table walker.

---
 rtl/factor_mult_seq.sv | 118 +++++++++++
 1 files changed

// File: rtl/factor_mult_seq.sv
// Sequential shift-and-add multiplier: accepts (x, y, target), produces x*y after
// WIDTH cycles and flags whether the pair is nontrivial and whether it hits target.
module factor_mult_seq #(
  parameter int WIDTH = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  input  logic [2*WIDTH-1:0] target,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               nontrivial,
  output logic               match
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t             state_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [2*WIDTH-1:0] tgt_q;
  logic [CW-1:0]      cnt_q;
  logic               nontriv_q;
  logic               outValid_q;
  logic [2*WIDTH-1:0] product_q;
  logic               match_q;
  logic               nontrivial_q;

  assign acc_d      = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign in_ready   = (state_q == IDLE) && rst;
  assign out_valid  = outValid_q;
  assign product    = product_q;
  assign match      = match_q;
  assign nontrivial = nontrivial_q;

  // The last MUL iteration loads the result registers from acc_d directly,
  // so out_valid rises exactly WIDTH edges after the accepting edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      mcand_q      <= '0;
      mplier_q     <= '0;
      acc_q        <= '0;
      tgt_q        <= '0;
      cnt_q        <= '0;
      nontriv_q    <= 1'b0;
      outValid_q   <= 1'b0;
      product_q    <= '0;
      match_q      <= 1'b0;
      nontrivial_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            mcand_q   <= {{WIDTH{1'b0}}, x};
            mplier_q  <= y;
            tgt_q     <= target;
            nontriv_q <= (x > WIDTH'(1)) && (y > WIDTH'(1));
            acc_q     <= '0;
            cnt_q     <= '0;
            state_q   <= MUL;
          end
        end
        MUL: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            product_q    <= acc_d;
            match_q      <= (acc_d == tgt_q);
            nontrivial_q <= nontriv_q;
            outValid_q   <= 1'b1;
            state_q      <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            outValid_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  logic [2*WIDTH-1:0] expProd_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      expProd_q <= '0;
    end else if (in_valid && in_ready) begin
      expProd_q <= {{WIDTH{1'b0}}, x} * {{WIDTH{1'b0}}, y};
    end
  end

  aProduct: assert property (@(posedge clk) disable iff (!rst)
    out_valid |-> (product == expProd_q));
  aHold: assert property (@(posedge clk) disable iff (!rst)
    (out_valid && !out_ready) |=> (out_valid && $stable(product) && $stable(match) && $stable(nontrivial)));
  aExclusive: assert property (@(posedge clk) disable iff (!rst)
    !(in_ready && out_valid));
  cHit: cover property (@(posedge clk) disable iff (!rst)
    out_valid && match && nontrivial);
`endif

endmodule
